// File: rtl/axi4stream_packet_assembler.sv
`timescale 1ns/1ps
// axi4stream_packet_assembler
// Packs a framed AXI4-Stream of AXI_WIDTH-bit beats into BUFFER_WIDTH-bit words
// (first beat in the LSBs), checks tlast framing and queues finished words in a
// small output FIFO with a valid/ready handshake.
module axi4stream_packet_assembler #(
  parameter int AXI_WIDTH    = 8,
  parameter int BUFFER_WIDTH = 35,
  parameter int DEPTH        = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [AXI_WIDTH-1:0]    tdata,
  input  logic                    tvalid,
  input  logic                    tlast,
  output logic                    tready,
  output logic [BUFFER_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    err_short,
  output logic                    err_long
);

  localparam int BEATS  = (BUFFER_WIDTH + AXI_WIDTH - 1) / AXI_WIDTH;
  localparam int LAST_W = BUFFER_WIDTH - (BEATS - 1) * AXI_WIDTH;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(DEPTH - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(DEPTH);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic                    run_q;
  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [BUFFER_WIDTH-1:0] word_q, word_d;
  logic [BUFFER_WIDTH-1:0] final_word;
  logic                    err_short_q, err_short_d;
  logic                    err_long_q, err_long_d;
  logic                    push;

  logic [BUFFER_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]       fcnt_q;

  logic is_final;
  logic fifo_full;
  logic beat_acc;
  logic pop;

  // tready depends only on registered state; the final beat waits for FIFO room.
  assign is_final  = (beat_cnt_q == LAST_IDX);
  assign fifo_full = (fcnt_q == FIFO_FULL);
  assign tready    = run_q && ((state_q == ST_DRAIN) || !is_final || !fifo_full);
  assign beat_acc  = tvalid && tready;
  assign m_valid   = (fcnt_q != '0);
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

  // Beat placement, framing checks and FILL/DRAIN transitions.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    word_d      = word_q;
    push        = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    final_word  = word_q;
    // Only the low LAST_W bits of the last beat fit in the word.
    final_word[BUFFER_WIDTH-1 -: LAST_W] = tdata[LAST_W-1:0];
    if (beat_acc) begin
      if (state_q == ST_DRAIN) begin
        if (tlast) begin
          state_d    = ST_FILL;
          beat_cnt_d = '0;
        end
      end else if (is_final) begin
        push       = 1'b1;
        beat_cnt_d = '0;
        if (!tlast) begin
          err_long_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end else if (tlast) begin
        err_short_d = 1'b1;
        beat_cnt_d  = '0;
      end else begin
        for (int k = 0; k < BEATS - 1; k++) begin
          if (beat_cnt_q == CNT_W'(k)) begin
            word_d[k*AXI_WIDTH +: AXI_WIDTH] = tdata;
          end
        end
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // Assembler state registers; run_q holds tready low through the reset cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      run_q       <= 1'b0;
      state_q     <= ST_FILL;
      beat_cnt_q  <= '0;
      word_q      <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      word_q      <= word_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  // FIFO storage: plain array, no reset so it can map onto RAM.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= final_word;
    end
  end

  // FIFO pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        fcnt_q <= fcnt_q + FCNT_W'(1);
      end else if (pop && !push) begin
        fcnt_q <= fcnt_q - FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi4stream_packet_assembler.sv
`timescale 1ns/1ps
// Testbench for axi4stream_packet_assembler (AXI_WIDTH=8, BUFFER_WIDTH=35, DEPTH=2).
// Expected words are queued when the final beat is driven and compared when popped.
module tb_axi4stream_packet_assembler;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [34:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        err_short;
  logic        err_long;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int short_seen = 0;
  int long_seen  = 0;
  int exp_short  = 0;
  int exp_long   = 0;

  logic [34:0] sb [$];

  axi4stream_packet_assembler #(
    .AXI_WIDTH(8), .BUFFER_WIDTH(35), .DEPTH(2)
  ) dut (
    .aclk(aclk), .areset(areset), .tdata(tdata), .tvalid(tvalid), .tlast(tlast),
    .tready(tready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3,
                                       input logic [7:0] b4);
    return {b4[2:0], b3, b2, b1, b0};
  endfunction

  // Output monitor: one line per popped word, error pulses counted per cycle.
  always @(negedge aclk) begin
    if (!areset) begin
      if (err_short) short_seen++;
      if (err_long)  long_seen++;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_word", {29'd0, m_data}, 64'h0);
        end else begin
          logic [34:0] exp_w;
          exp_w = sb.pop_front();
          check_eq("m_data", {29'd0, m_data}, {29'd0, exp_w});
          $display("pop word %09h (expected %09h)", m_data, exp_w);
        end
      end
    end
  end

  // Drive one beat and hold it until accepted (called at posedge+1).
  task automatic send_beat(input logic [7:0] d, input logic l);
    logic ok;
    int   n;
    tdata  = d;
    tvalid = 1'b1;
    tlast  = l;
    ok = 1'b0;
    n  = 0;
    while (!ok) begin
      @(negedge aclk);
      ok = tready;
      @(posedge aclk);
      #1;
      n++;
      if (!ok && n > 200) begin
        check_eq("tready_timeout", 64'd0, 64'd1);
        ok = 1'b1;
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    send_beat(b0, 1'b0);
    send_beat(b1, 1'b0);
    send_beat(b2, 1'b0);
    send_beat(b3, 1'b0);
    sb.push_back(pack(b0, b1, b2, b3, b4));
    send_beat(b4, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < 100) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check_eq(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_errs(input string tag);
    idle(3);
    check_eq({tag, "_short"}, 64'(short_seen), 64'(exp_short));
    check_eq({tag, "_long"},  64'(long_seen),  64'(exp_long));
  endtask

  initial begin
    areset  = 1'b1;
    tdata   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    check_eq("rst_tready",  {63'd0, tready},    64'd0);
    check_eq("rst_m_valid", {63'd0, m_valid},   64'd0);
    check_eq("rst_m_data",  {29'd0, m_data},    64'd0);
    check_eq("rst_err",     {62'd0, err_short, err_long}, 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_eq("tready_after_rst", {63'd0, tready}, 64'd1);
    @(posedge aclk);
    #1;

    // Test 1: gap mid-frame, one-cycle latency, m_valid for a single cycle
    $display("test1: AA gap BB CC DD 05");
    send_beat(8'hAA, 1'b0);
    idle(1);
    send_beat(8'hBB, 1'b0);
    send_beat(8'hCC, 1'b0);
    send_beat(8'hDD, 1'b0);
    sb.push_back(35'h5_DDCC_BBAA);
    send_beat(8'h05, 1'b1);
    @(negedge aclk);
    check_eq("t1_latency", {63'd0, m_valid}, 64'd1);
    @(posedge aclk);
    @(negedge aclk);
    check_eq("t1_one_cycle", {63'd0, m_valid}, 64'd0);
    @(posedge aclk);
    #1;
    wait_drain("t1_drain");
    check_errs("t1_err");

    // Test 2: upper bits of the final beat are dropped
    $display("test2: EF BE AD DE FF");
    sb.push_back(35'h7_DEAD_BEEF);
    send_beat(8'hEF, 1'b0);
    send_beat(8'hBE, 1'b0);
    send_beat(8'hAD, 1'b0);
    send_beat(8'hDE, 1'b0);
    send_beat(8'hFF, 1'b1);
    wait_drain("t2_drain");
    check_errs("t2_err");

    // Test 3: backpressure fills the FIFO and stalls the third frame's final beat
    $display("test3: backpressure, three frames");
    m_ready = 1'b0;
    send_frame(8'h10, 8'h11, 8'h12, 8'h13, 8'h04);
    send_frame(8'h20, 8'h21, 8'h22, 8'h23, 8'h02);
    send_beat(8'h30, 1'b0);
    send_beat(8'h31, 1'b0);
    send_beat(8'h32, 1'b0);
    send_beat(8'h33, 1'b0);
    check_eq("t3_two_held", 64'(sb.size()), 64'd2);
    sb.push_back(pack(8'h30, 8'h31, 8'h32, 8'h33, 8'h06));
    tdata  = 8'h06;
    tvalid = 1'b1;
    tlast  = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check_eq("t3_stall",  {63'd0, tready}, 64'd0);
      check_eq("t3_m_valid", {63'd0, m_valid}, 64'd1);
      check_eq("t3_hold",   {29'd0, m_data}, {29'd0, sb[0]});
      @(posedge aclk);
      #1;
    end
    m_ready = 1'b1;
    send_beat(8'h06, 1'b1);
    wait_drain("t3_drain");
    check_errs("t3_err");

    // Test 4: short frame raises err_short, nothing pushed
    $display("test4: short frame 11 22");
    send_beat(8'h11, 1'b0);
    exp_short++;
    send_beat(8'h22, 1'b1);
    check_errs("t4_err");
    check_eq("t4_no_word", {63'd0, m_valid}, 64'd0);
    send_frame(8'h41, 8'h42, 8'h43, 8'h44, 8'h01);
    wait_drain("t4_drain");

    // Test 5: long frame pushes the word, drops the tail, raises err_long
    $display("test5: long frame 01..07");
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b0);
    sb.push_back(35'h5_0403_0201);
    exp_long++;
    send_beat(8'h05, 1'b0);
    send_beat(8'h06, 1'b0);
    send_beat(8'h07, 1'b1);
    wait_drain("t5_drain");
    check_errs("t5_err");
    send_frame(8'h51, 8'h52, 8'h53, 8'h54, 8'h03);
    wait_drain("t5_next");

    // Test 6: reset mid-frame discards the partial word
    $display("test6: reset mid-frame");
    send_beat(8'h61, 1'b0);
    send_beat(8'h62, 1'b0);
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check_eq("t6_tready",  {63'd0, tready},  64'd0);
    check_eq("t6_m_valid", {63'd0, m_valid}, 64'd0);
    check_eq("t6_m_data",  {29'd0, m_data},  64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    send_frame(8'h71, 8'h72, 8'h73, 8'h74, 8'h07);
    wait_drain("t6_drain");
    check_errs("t6_err");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
